led_ctrl: RTL and testbench



---
 rtl/led_pkg.sv | 9 +
 rtl/key_debounce.sv | 46 ++++
 rtl/led_ctrl.sv | 89 ++++++++
 tb/tb_led_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED-bank mode encoding for led_ctrl and its helpers.
package led_pkg;
   typedef enum logic [1:0] {
      MODE_DIRECT  = 2'd0,
      MODE_TOGGLE  = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_MARQUEE = 2'd3
   } mode_e;
endpackage

// File: rtl/key_debounce.sv
// One push-key: 2-flop sync, stable-count debounce, registered press pulse.
// Latency: level accepted DEB_CYC cycles after the synced input settles; pulse one cycle later. No backpressure.
module key_debounce
   import led_pkg::*;
#(
   parameter int DEB_CYC = 240000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic deb,
   output logic evt
);

   localparam int            CW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

   logic          s1, s2, deb_d1;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= 1'b1;
         s2     <= 1'b1;
         deb    <= 1'b1;
         deb_d1 <= 1'b1;
         cnt    <= '0;
         evt    <= 1'b0;
      end else begin
         s1     <= key;
         s2     <= s1;
         deb_d1 <= deb;
         // falling edge of the debounced level is a press (keys are active-low)
         evt    <= deb_d1 & ~deb;
         if (s2 == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            deb <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_ctrl.sv
// Key/switch LED bank: debounced keys, synced switches, direct/toggle/blink/marquee modes.
// Latency: led registered one cycle after its inputs; key_evt one cycle after debounce. No backpressure.
module led_ctrl
   import led_pkg::*;
#(
   parameter int N_KEY     = 4,
   parameter int N_SW      = 4,
   parameter int DEB_CYC   = 240000,
   parameter int BLINK_CYC = 3000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_KEY-1:0]      key,
   input  logic [N_SW-1:0]       sw,
   input  logic [1:0]            mode,
   output logic [N_KEY+N_SW-1:0] led,
   output logic [N_KEY-1:0]      key_evt
);

   localparam int            W        = N_KEY + N_SW;
   localparam int            TW       = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
   localparam int            PW       = $clog2(W);
   localparam logic [TW-1:0] TICK_MAX = TW'(BLINK_CYC - 1);
   localparam logic [PW-1:0] POS_MAX  = PW'(W - 1);

   mode_e            m;
   logic [N_KEY-1:0] deb, tl;
   logic [N_SW-1:0]  sw_s1, sw_s2;
   logic [TW-1:0]    tcnt;
   logic             tick, phase;
   logic [PW-1:0]    pos, pos_nxt;
   logic [W-1:0]     led_nxt;

   for (genvar i = 0; i < N_KEY; i++) begin : g_key
      key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
         .clk (clk),
         .rst (rst),
         .key (key[i]),
         .deb (deb[i]),
         .evt (key_evt[i])
      );
   end

   assign m    = mode_e'(mode);
   assign tick = (tcnt == TICK_MAX);

   // W need not be a power of two, so both wrap points are explicit
   always_comb begin
      pos_nxt = pos;
      if (m != MODE_MARQUEE) begin
         pos_nxt = '0;
      end else if (tick) begin
         if (!sw_s2[0]) pos_nxt = (pos == POS_MAX) ? '0 : pos + 1'b1;
         else           pos_nxt = (pos == '0) ? POS_MAX : pos - 1'b1;
      end
   end

   always_comb begin
      led_nxt = '1;
      case (m)
         MODE_DIRECT:  led_nxt = ~{~deb, sw_s2};
         MODE_TOGGLE:  led_nxt = ~{tl, sw_s2};
         MODE_BLINK:   led_nxt = phase ? '1 : ~{tl, sw_s2};
         MODE_MARQUEE: led_nxt = ~(W'(1) << pos);
         default:      led_nxt = '1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
         tl    <= '0;
         tcnt  <= '0;
         phase <= 1'b0;
         pos   <= '0;
         led   <= '1;
      end else begin
         sw_s1 <= sw;
         sw_s2 <= sw_s1;
         tl    <= tl ^ key_evt;
         tcnt  <= tick ? '0 : tcnt + 1'b1;
         if (tick) phase <= ~phase;
         pos   <= pos_nxt;
         led   <= led_nxt;
      end
   end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with short debounce/timebase periods.
module tb_led_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key;
   logic [3:0] sw;
   logic [1:0] mode;
   logic [7:0] led;
   logic [3:0] key_evt;

   int n_vec = 0;
   int n_err = 0;

   led_ctrl #(.N_KEY(4), .N_SW(4), .DEB_CYC(4), .BLINK_CYC(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .key     (key),
      .sw      (sw),
      .mode    (mode),
      .led     (led),
      .key_evt (key_evt)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h, required %h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_led(input logic [7:0] v, input int max, input string tag);
      int k = 0;
      while (led !== v && k < max) begin
         cyc(1);
         k++;
      end
      chk(tag, led, v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] marq [8];
      marq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

      rst = 1'b1; key = 4'hF; sw = 4'h5; mode = 2'd0;
      cyc(2);
      chk("rst_led", led, 8'hFF);
      chk("rst_evt", {4'h0, key_evt}, 8'h00);
      rst = 1'b0;
      cyc(4);
      chk("direct_idle", led, 8'hFA);

      // 1: key[0] press latency
      key = 4'hE;
      cyc(6);
      chk("t1_led_pre", led, 8'hFA);
      chk("t1_evt_pre", {4'h0, key_evt}, 8'h00);
      cyc(1);
      chk("t1_led", led, 8'hEA);
      chk("t1_evt", {4'h0, key_evt}, 8'h01);
      cyc(1);
      chk("t1_evt_once", {4'h0, key_evt}, 8'h00);
      key = 4'hF;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         chk("t1_rel_evt", {4'h0, key_evt}, 8'h00);
      end
      chk("t1_rel_led", led, 8'hFA);

      // 2: 3-cycle glitch rejected, 4-cycle glitch accepted
      key = 4'hD;
      cyc(3);
      key = 4'hF;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("t2_short_led", led, 8'hFA);
         chk("t2_short_evt", {4'h0, key_evt}, 8'h00);
      end
      key = 4'hD;
      cyc(4);
      key = 4'hF;
      cyc(3);
      chk("t2_long_evt", {4'h0, key_evt}, 8'h02);
      chk("t2_long_led", led, 8'hDA);
      cyc(5);
      chk("t2_long_rel", led, 8'hFA);

      // 3: toggle latch from a clean reset
      rst = 1'b1;
      cyc(1);
      rst = 1'b0; mode = 2'd1;
      cyc(4);
      chk("t3_idle", led, 8'hFA);
      key = 4'hB;
      cyc(8);
      chk("t3_pre", led, 8'hFA);
      cyc(1);
      chk("t3_on", led, 8'hBA);
      key = 4'hF;
      cyc(12);
      chk("t3_on_hold", led, 8'hBA);
      key = 4'hB;
      cyc(9);
      chk("t3_off", led, 8'hFA);
      key = 4'hF;
      cyc(12);
      chk("t3_off_hold", led, 8'hFA);

      // 4: blink with tl=1, sw=0
      key = 4'hE;
      cyc(10);
      key = 4'hF;
      cyc(12);
      sw = 4'h0; mode = 2'd2;
      wait_led(8'hEF, 20, "t4_sync_on");
      wait_led(8'hFF, 20, "t4_sync_off");
      cyc(7);
      chk("t4_off_hold", led, 8'hFF);
      cyc(1);
      chk("t4_on", led, 8'hEF);
      cyc(7);
      chk("t4_on_hold", led, 8'hEF);
      cyc(1);
      chk("t4_off", led, 8'hFF);
      cyc(8);
      chk("t4_on2", led, 8'hEF);

      // 5: marquee forward, wrap, then reverse wrap
      mode = 2'd3;
      cyc(1);
      chk("t5_entry", led, 8'hFE);
      wait_led(8'hFD, 12, "t5_first");
      for (int i = 2; i <= 8; i++) begin
         cyc(8);
         chk("t5_step", led, marq[i % 8]);
      end
      sw = 4'h1;
      cyc(8);
      chk("t5_rev_wrap", led, 8'h7F);
      cyc(8);
      chk("t5_rev_step", led, 8'hBF);

      // 6: reset mid-marquee with all toggle latches set
      mode = 2'd1; key = 4'h1;
      cyc(10);
      key = 4'hF;
      cyc(12);
      chk("t6_tl_all", led, 8'h0E);
      mode = 2'd3;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      chk("t6_rst_led", led, 8'hFF);
      chk("t6_rst_evt", {4'h0, key_evt}, 8'h00);
      sw = 4'h5;
      cyc(2);
      chk("t6_rst_hold", led, 8'hFF);
      rst = 1'b0;
      cyc(1);
      chk("t6_pos0", led, 8'hFE);
      mode = 2'd1;
      cyc(3);
      chk("t6_tl_clr", led, 8'hFA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
